writeback_sequencer: RTL and testbench
======================================

# writeback_sequencer

Execute-to-writeback stage placed directly downstream of the ALU and the flag register's next-state path. It captures one ALU result bundle per handshake and drives the single-port register file write. Dual-result operations (MUL: low/high product; DIV: quotient/remainder) are serialised over two write cycles to rd and rd+1, with upstream back-pressure while the second write is pending. It also issues exactly one flag-commit strobe per instruction.

## Interface
Parameters:
- DATA_W, 16, datapath width; matches ALU result_0/result_1.
- FLAG_W, 16, flag word width; matches next_flags/current_flags.
- REG_ADDR_W, 3, register-file address width; rd+1 wraps modulo 2^REG_ADDR_W.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately when low.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept a bundle this cycle.
- in_opcode  in  5  opcode of the bundle, encoded per the shared opcode macros.
- in_rd  in  REG_ADDR_W  destination register.
- in_wr_en  in  1  instruction writes a register (0 for CMP, SETF, CLRF, CPLF).
- in_result_0  in  DATA_W  ALU result_0.
- in_result_1  in  DATA_W  ALU result_1 (high product or remainder).
- in_flags  in  FLAG_W  ALU next_flags for this instruction.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  REG_ADDR_W  write address.
- rf_wdata  out  DATA_W  write data; also the forwarding bypass value.
- flags_we  out  1  flag-register commit strobe.
- flags_wdata  out  FLAG_W  flag word to commit.
- busy  out  1  a captured bundle is still being written.

## Operation
- Capture occurs when in_valid && in_ready. Opcode, rd, wr_en, both results and flags are latched. dual = in_wr_en && (opcode == MUL || opcode == DIV).
- FSM states:
  - IDLE: no bundle held. On capture, go to WR_LO.
  - WR_LO: rf_we = wr_en_q, rf_waddr = rd_q, rf_wdata = result_0_q.
    - If not dual: flags_we = 1 with flags_q. Next state is WR_LO on a new capture, otherwise IDLE.
    - If dual: flags_we = 0; go to WR_HI.
  - WR_HI: rf_we = 1, rf_waddr = rd_q + 1 (wraps), rf_wdata = result_1_q, flags_we = 1 with flags_q. Next state is WR_LO on a new capture, otherwise IDLE.
- in_ready = (state == IDLE) || (state == WR_LO && !dual_q) || (state == WR_HI). in_ready is combinational from state only and never depends on in_valid.
- A bundle with in_wr_en = 0 still occupies one WR_LO cycle so its flags commit in order; rf_we stays 0 during that cycle.
- DIV by zero is not special-cased: result_1 is written as presented, and flags_q carries V = 1 from the ALU.
- busy = (state != IDLE).
- When rf_we = 0, flags_we = 0 or in IDLE, rf_waddr, rf_wdata and flags_wdata are 0.

## Timing
- Reset (reset low, asynchronous): state IDLE; all latched fields 0; rf_we 0, rf_waddr 0, rf_wdata 0, flags_we 0, flags_wdata 0, busy 0. in_ready reads 1 once reset is released.
- Reset mid-operation (WR_LO or WR_HI) abandons the bundle; no further write or flag commit from it.
- Latency: the low write and the commit of a single-result bundle occur in the cycle after capture. The high write occurs 2 cycles after capture.
- Throughput: 1 bundle/cycle for single-result bundles; 1 per 2 cycles for MUL/DIV.
- Simultaneous final write and new capture: the final write completes and the new bundle's WR_LO follows the next cycle with no bubble.
- Commit order equals capture order; exactly one flags_we pulse per captured bundle.

## Structure
- Opcode macros (ADD, MUL, DIV, CMP, SETF, CLRF, CPLF, …) come from the shared parameters.v include.
- Add WB_IDLE, WB_WR_LO and WB_WR_HI state encodings (2-bit) to parameters.v.
- Single flat module; no sub-module. The capture register and FSM are small enough to stay inline.

## Test plan
- Reset then ADD: rd=3, result_0=16'h1234, flags=16'h0020 → next cycle rf_we=1, waddr=3, wdata=16'h1234, flags_we=1, flags_wdata=16'h0020; in_ready stays 1.
- MUL: rd=7, result_0=16'h5678, result_1=16'h0012 → cycle+1 writes 16'h5678 to r7 with flags_we=0 and in_ready=0; cycle+2 writes 16'h0012 to r0 (wrap) with flags_we=1.
- CMP with in_wr_en=0, flags=16'h0008 → rf_we=0, flags_we=1, flags_wdata=16'h0008, in one cycle.
- Back-to-back stream ADD, DIV (rd=2, q=5, r=1), ADD with in_valid held high → writes r_a, r2=5, r3=1, r_b on consecutive cycles; exactly 3 flags_we pulses; in_ready low only during the DIV WR_LO cycle.
- Assert reset during MUL WR_LO → all outputs 0 immediately; no r(rd+1) write and no flags_we after release; in_ready=1.
- Hold in_valid=0 after a bundle → state returns to IDLE, busy=0, all write strobes 0.

Source files
------------

// File: rtl/writeback_sequencer_pkg.sv
// Shared opcode encodings, writeback FSM state encodings and helpers
// used by the execute-to-writeback stage.
package writeback_sequencer_pkg;

  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned STATE_W  = 2;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'h00;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'h01;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'h02;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'h03;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 5'h04;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 5'h08;
  localparam logic [OPCODE_W-1:0] OP_DIV  = 5'h09;
  localparam logic [OPCODE_W-1:0] OP_CMP  = 5'h0A;
  localparam logic [OPCODE_W-1:0] OP_SETF = 5'h0C;
  localparam logic [OPCODE_W-1:0] OP_CLRF = 5'h0D;
  localparam logic [OPCODE_W-1:0] OP_CPLF = 5'h0E;

  localparam logic [STATE_W-1:0] WB_IDLE  = 2'b00;
  localparam logic [STATE_W-1:0] WB_WR_LO = 2'b01;
  localparam logic [STATE_W-1:0] WB_WR_HI = 2'b10;

  // A bundle needs two register writes only if it writes and produces two results.
  function automatic logic is_dual(input logic [OPCODE_W-1:0] opcode,
                                   input logic                wr_en);
    return wr_en && ((opcode == OP_MUL) || (opcode == OP_DIV));
  endfunction

endpackage

// File: rtl/writeback_sequencer.sv
// Captures one ALU result bundle per handshake and sequences the register-file
// write(s) and the single flag commit for it; MUL/DIV take two write cycles.
module writeback_sequencer
  import writeback_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FLAG_W     = 16,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPCODE_W-1:0]   in_opcode,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wr_en,
  input  logic [DATA_W-1:0]     in_result_0,
  input  logic [DATA_W-1:0]     in_result_1,
  input  logic [FLAG_W-1:0]     in_flags,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  flags_we,
  output logic [FLAG_W-1:0]     flags_wdata,
  output logic                  busy
);

  logic [STATE_W-1:0]    state_q,    state_d;
  logic [OPCODE_W-1:0]   opcode_q,   opcode_d;
  logic [REG_ADDR_W-1:0] rd_q,       rd_d;
  logic                  wr_en_q,    wr_en_d;
  logic [DATA_W-1:0]     result_0_q, result_0_d;
  logic [DATA_W-1:0]     result_1_q, result_1_d;
  logic [FLAG_W-1:0]     flags_q,    flags_d;

  logic                  rf_we_q,       rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q,    rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q,    rf_wdata_d;
  logic                  flags_we_q,    flags_we_d;
  logic [FLAG_W-1:0]     flags_wdata_q, flags_wdata_d;
  logic                  busy_q,        busy_d;

  logic dual_q;
  logic dual_d;
  logic capture;

  assign dual_q   = is_dual(opcode_q, wr_en_q);
  assign in_ready = (state_q == WB_IDLE) ||
                    ((state_q == WB_WR_LO) && !dual_q) ||
                    (state_q == WB_WR_HI);
  assign capture  = in_valid && in_ready;

  // Next state and capture register.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    rd_d       = rd_q;
    wr_en_d    = wr_en_q;
    result_0_d = result_0_q;
    result_1_d = result_1_q;
    flags_d    = flags_q;

    if (capture) begin
      opcode_d   = in_opcode;
      rd_d       = in_rd;
      wr_en_d    = in_wr_en;
      result_0_d = in_result_0;
      result_1_d = in_result_1;
      flags_d    = in_flags;
    end

    case (state_q)
      WB_IDLE:  if (capture) state_d = WB_WR_LO;
      WB_WR_LO: begin
        if (dual_q)       state_d = WB_WR_HI;
        else if (capture) state_d = WB_WR_LO;
        else              state_d = WB_IDLE;
      end
      WB_WR_HI: state_d = capture ? WB_WR_LO : WB_IDLE;
      default:  state_d = WB_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they appear registered.
  always_comb begin
    rf_we_d       = 1'b0;
    rf_waddr_d    = '0;
    rf_wdata_d    = '0;
    flags_we_d    = 1'b0;
    flags_wdata_d = '0;
    busy_d        = (state_d != WB_IDLE);
    dual_d        = is_dual(opcode_d, wr_en_d);

    case (state_d)
      WB_WR_LO: begin
        rf_we_d = wr_en_d;
        if (wr_en_d) begin
          rf_waddr_d = rd_d;
          rf_wdata_d = result_0_d;
        end
        if (!dual_d) begin
          flags_we_d    = 1'b1;
          flags_wdata_d = flags_d;
        end
      end
      WB_WR_HI: begin
        rf_we_d       = 1'b1;
        rf_waddr_d    = rd_d + REG_ADDR_W'(1);
        rf_wdata_d    = result_1_d;
        flags_we_d    = 1'b1;
        flags_wdata_d = flags_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= WB_IDLE;
      opcode_q      <= '0;
      rd_q          <= '0;
      wr_en_q       <= 1'b0;
      result_0_q    <= '0;
      result_1_q    <= '0;
      flags_q       <= '0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      flags_we_q    <= 1'b0;
      flags_wdata_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      rd_q          <= rd_d;
      wr_en_q       <= wr_en_d;
      result_0_q    <= result_0_d;
      result_1_q    <= result_1_d;
      flags_q       <= flags_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      flags_we_q    <= flags_we_d;
      flags_wdata_q <= flags_wdata_d;
      busy_q        <= busy_d;
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign flags_we    = flags_we_q;
  assign flags_wdata = flags_wdata_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed bench for writeback_sequencer: inputs change on the falling edge,
// outputs are compared on the falling edge after each capturing rising edge.
module tb_writeback_sequencer;
  import writeback_sequencer_pkg::*;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FLAG_W     = 16;
  localparam int unsigned REG_ADDR_W = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [OPCODE_W-1:0]   in_opcode;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_wr_en;
  logic [DATA_W-1:0]     in_result_0;
  logic [DATA_W-1:0]     in_result_1;
  logic [FLAG_W-1:0]     in_flags;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  flags_we;
  logic [FLAG_W-1:0]     flags_wdata;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  // {rf_we, rf_waddr, rf_wdata, flags_we, flags_wdata, in_ready, busy}
  logic [38:0] obs;
  assign obs = {rf_we, rf_waddr, rf_wdata, flags_we, flags_wdata, in_ready, busy};

  writeback_sequencer #(
    .DATA_W(DATA_W), .FLAG_W(FLAG_W), .REG_ADDR_W(REG_ADDR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .in_result_0(in_result_0), .in_result_1(in_result_1), .in_flags(in_flags),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flags_we(flags_we), .flags_wdata(flags_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] rd,
                       input logic we, input logic [15:0] r0, input logic [15:0] r1,
                       input logic [15:0] fl);
    in_valid    = v;
    in_opcode   = op;
    in_rd       = rd;
    in_wr_en    = we;
    in_result_0 = r0;
    in_result_1 = r1;
    in_flags    = fl;
  endtask

  task automatic idle_inputs();
    drive(1'b0, OP_ADD, 3'd0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #12;
    checks++;
    if (obs !== {1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs,
               {1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_add();
    drive(1'b1, OP_ADD, 3'd3, 1'b1, 16'h1234, 16'h0, 16'h0020);
    @(negedge clk);
    idle_inputs();
    checks++;
    if (obs !== {1'b1, 3'd3, 16'h1234, 1'b1, 16'h0020, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL add_write: got %h expected %h", obs,
               {1'b1, 3'd3, 16'h1234, 1'b1, 16'h0020, 1'b1, 1'b1});
    end
    @(negedge clk);
    checks++;
    if (obs !== {1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_idle: got %h expected %h", obs,
               {1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_mul_wrap();
    drive(1'b1, OP_MUL, 3'd7, 1'b1, 16'h5678, 16'h0012, 16'h0004);
    @(negedge clk);
    idle_inputs();
    checks++;
    if (obs !== {1'b1, 3'd7, 16'h5678, 1'b0, 16'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mul_lo: got %h expected %h", obs,
               {1'b1, 3'd7, 16'h5678, 1'b0, 16'h0, 1'b0, 1'b1});
    end
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 3'd0, 16'h0012, 1'b1, 16'h0004, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL mul_hi_wrap: got %h expected %h", obs,
               {1'b1, 3'd0, 16'h0012, 1'b1, 16'h0004, 1'b1, 1'b1});
    end
    @(negedge clk);
    checks++;
    if (obs !== {1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mul_idle: got %h expected %h", obs,
               {1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_cmp_no_write();
    drive(1'b1, OP_CMP, 3'd5, 1'b0, 16'hDEAD, 16'hBEEF, 16'h0008);
    @(negedge clk);
    // MUL with wr_en=0 is not dual: one cycle, flags only
    drive(1'b1, OP_MUL, 3'd6, 1'b0, 16'h1111, 16'h2222, 16'h0010);
    checks++;
    if (obs !== {1'b0, 3'd0, 16'h0, 1'b1, 16'h0008, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL cmp_flags_only: got %h expected %h", obs,
               {1'b0, 3'd0, 16'h0, 1'b1, 16'h0008, 1'b1, 1'b1});
    end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (obs !== {1'b0, 3'd0, 16'h0, 1'b1, 16'h0010, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL mul_nowr_single: got %h expected %h", obs,
               {1'b0, 3'd0, 16'h0, 1'b1, 16'h0010, 1'b1, 1'b1});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    drive(1'b1, OP_ADD, 3'd1, 1'b1, 16'hAAAA, 16'h0, 16'h0001);
    @(negedge clk);
    pulses += int'(flags_we);
    checks++;
    if (obs !== {1'b1, 3'd1, 16'hAAAA, 1'b1, 16'h0001, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_add_a: got %h expected %h", obs,
               {1'b1, 3'd1, 16'hAAAA, 1'b1, 16'h0001, 1'b1, 1'b1});
    end
    // DIV by zero style: remainder written as presented, V flag passed through
    drive(1'b1, OP_DIV, 3'd2, 1'b1, 16'h0005, 16'h0001, 16'h0002);
    @(negedge clk);
    pulses += int'(flags_we);
    checks++;
    if (obs !== {1'b1, 3'd2, 16'h0005, 1'b0, 16'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_div_lo: got %h expected %h", obs,
               {1'b1, 3'd2, 16'h0005, 1'b0, 16'h0, 1'b0, 1'b1});
    end
    drive(1'b1, OP_ADD, 3'd5, 1'b1, 16'hBBBB, 16'h0, 16'h0004);
    @(negedge clk);
    pulses += int'(flags_we);
    checks++;
    if (obs !== {1'b1, 3'd3, 16'h0001, 1'b1, 16'h0002, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_div_hi: got %h expected %h", obs,
               {1'b1, 3'd3, 16'h0001, 1'b1, 16'h0002, 1'b1, 1'b1});
    end
    @(negedge clk);
    idle_inputs();
    pulses += int'(flags_we);
    checks++;
    if (obs !== {1'b1, 3'd5, 16'hBBBB, 1'b1, 16'h0004, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_add_b: got %h expected %h", obs,
               {1'b1, 3'd5, 16'hBBBB, 1'b1, 16'h0004, 1'b1, 1'b1});
    end
    @(negedge clk);
    pulses += int'(flags_we);
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL b2b_flag_pulses: got %0d expected 3", pulses);
    end
  endtask

  task automatic test_reset_mid_mul();
    drive(1'b1, OP_MUL, 3'd4, 1'b1, 16'h0F0F, 16'hF0F0, 16'h0001);
    @(negedge clk);
    idle_inputs();
    checks++;
    if (obs !== {1'b1, 3'd4, 16'h0F0F, 1'b0, 16'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_lo: got %h expected %h", obs,
               {1'b1, 3'd4, 16'h0F0F, 1'b0, 16'h0, 1'b0, 1'b1});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs !== {1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_immediate: got %h expected %h", obs,
               {1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== {1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL rstmid_after_%0d: got %h expected %h", i, obs,
                 {1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_idle_hold();
    drive(1'b1, OP_SUB, 3'd6, 1'b1, 16'h7777, 16'h0, 16'h0080);
    @(negedge clk);
    idle_inputs();
    checks++;
    if (obs !== {1'b1, 3'd6, 16'h7777, 1'b1, 16'h0080, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL idle_sub: got %h expected %h", obs,
               {1'b1, 3'd6, 16'h7777, 1'b1, 16'h0080, 1'b1, 1'b1});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== {1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL idle_hold_%0d: got %h expected %h", i, obs,
                 {1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_wrap();
    test_cmp_no_write();
    test_back_to_back();
    test_reset_mid_mul();
    test_idle_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
